// File: rtl/pwm_deadtime.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pwm_deadtime                                                 |
// | Description : Complementary gate-drive generator. Each channel converts    |
// |               one PWM bit into a high-side / low-side pair separated by a  |
// |               programmable dead-time gap, with per-channel enable and a    |
// |               sticky, shared fault shutdown.                               |
// | Ports       : i_wb_clk     system clock                                    |
// |               i_wb_rst_n   asynchronous active-low reset                   |
// |               i_pwm        PWM timer outputs (asynchronous)                |
// |               i_en         per-channel enable (level)                      |
// |               i_dead       per-channel dead time, dt_width bits each       |
// |               i_fault      external fault (asynchronous, active-high)      |
// |               i_fault_clr  one-cycle pulse that clears a latched fault     |
// |               o_hs / o_ls  high-side / low-side gate drives                |
// |               o_fault_sts  fault latch status                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pwm_deadtime #(
  parameter int num_ch   = 4,
  parameter int dt_width = 8
) (
  input  logic                       i_wb_clk,
  input  logic                       i_wb_rst_n,
  input  logic [num_ch-1:0]          i_pwm,
  input  logic [num_ch-1:0]          i_en,
  input  logic [num_ch*dt_width-1:0] i_dead,
  input  logic                       i_fault,
  input  logic                       i_fault_clr,
  output logic [num_ch-1:0]          o_hs,
  output logic [num_ch-1:0]          o_ls,
  output logic                       o_fault_sts
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOW    = 3'd1,
    ST_DEAD_R = 3'd2,
    ST_HIGH   = 3'd3,
    ST_DEAD_F = 3'd4
  } state_t;

  // Two-flop synchronizers for the asynchronous inputs.
  logic [num_ch-1:0] pwm_meta_q;
  logic [num_ch-1:0] pwm_s_q;
  logic              fault_meta_q;
  logic              fault_s_q;
  logic              fault_q;
  logic              fault_d;

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      pwm_meta_q   <= '0;
      pwm_s_q      <= '0;
      fault_meta_q <= 1'b0;
      fault_s_q    <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      pwm_meta_q   <= i_pwm;
      pwm_s_q      <= pwm_meta_q;
      fault_meta_q <= i_fault;
      fault_s_q    <= fault_meta_q;
      fault_q      <= fault_d;
    end
  end

  // A clear request is only honoured once the synchronized fault has gone away.
  always_comb begin
    fault_d = fault_q;
    if (fault_s_q) begin
      fault_d = 1'b1;
    end else if (i_fault_clr) begin
      fault_d = 1'b0;
    end
  end

  assign o_fault_sts = fault_q;

  for (genvar i = 0; i < num_ch; i++) begin : g_ch
    state_t              state_q;
    state_t              state_d;
    logic [dt_width-1:0] cnt_q;
    logic [dt_width-1:0] cnt_d;
    logic [dt_width-1:0] dead;
    logic                hs_q;
    logic                ls_q;

    // Dead time is only captured on entry to a dead state, so a gap in
    // progress is immune to later changes of i_dead.
    assign dead = i_dead[dt_width*i +: dt_width];

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (fault_s_q || !i_en[i]) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (!fault_q) state_d = ST_LOW;
          end
          ST_LOW: begin
            if (pwm_s_q[i]) begin
              if (dead == '0) begin
                state_d = ST_HIGH;
              end else begin
                state_d = ST_DEAD_R;
                cnt_d   = dead;
              end
            end
          end
          ST_DEAD_R: begin
            if (!pwm_s_q[i]) begin
              // Pulse shorter than the dead time: swallow it.
              state_d = ST_LOW;
              cnt_d   = '0;
            end else if (cnt_q == dt_width'(1)) begin
              state_d = ST_HIGH;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - dt_width'(1);
            end
          end
          ST_HIGH: begin
            if (!pwm_s_q[i]) begin
              if (dead == '0) begin
                state_d = ST_LOW;
              end else begin
                state_d = ST_DEAD_F;
                cnt_d   = dead;
              end
            end
          end
          ST_DEAD_F: begin
            if (pwm_s_q[i]) begin
              // Low glitch shorter than the dead time: back to high side.
              state_d = ST_HIGH;
              cnt_d   = '0;
            end else if (cnt_q == dt_width'(1)) begin
              state_d = ST_LOW;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - dt_width'(1);
            end
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end

    // Outputs are decoded from the next state and registered alongside it,
    // so they are glitch-free and can never both be high.
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        hs_q    <= 1'b0;
        ls_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        hs_q    <= (state_d == ST_HIGH);
        ls_q    <= (state_d == ST_LOW);
      end
    end

    assign o_hs[i] = hs_q;
    assign o_ls[i] = ls_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_deadtime.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pwm_deadtime                                              |
// | Description : Self-checking bench for pwm_deadtime. Channels use dead      |
// |               times ch0=4, ch1=0, ch2=2, ch3=1.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pwm_deadtime;

  localparam int NUM_CH = 4;
  localparam int DT_W   = 8;

  logic                     clk;
  logic                     clk_run;
  logic                     rst_n;
  logic [NUM_CH-1:0]        pwm;
  logic [NUM_CH-1:0]        en;
  logic [NUM_CH*DT_W-1:0]   dead;
  logic                     fault;
  logic                     fault_clr;
  logic [NUM_CH-1:0]        hs;
  logic [NUM_CH-1:0]        ls;
  logic                     fault_sts;

  int n_vec;
  int n_err;

  typedef struct {
    logic       pwm;
    logic [3:0] hs;
    logic [3:0] ls;
  } vec_t;

  vec_t tbl[$];

  pwm_deadtime #(.num_ch(NUM_CH), .dt_width(DT_W)) dut (
    .i_wb_clk    (clk),
    .i_wb_rst_n  (rst_n),
    .i_pwm       (pwm),
    .i_en        (en),
    .i_dead      (dead),
    .i_fault     (fault),
    .i_fault_clr (fault_clr),
    .o_hs        (hs),
    .o_ls        (ls),
    .o_fault_sts (fault_sts)
  );

  initial clk = 1'b0;
  always #5 if (clk_run) clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic p, input logic [3:0] h, input logic [3:0] l);
    vec_t v;
    v.pwm = p;
    v.hs  = h;
    v.ls  = l;
    tbl.push_back(v);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    clk_run   = 1'b1;
    rst_n     = 1'b0;
    pwm       = '0;
    en        = '0;
    fault     = 1'b0;
    fault_clr = 1'b0;
    dead      = {8'd1, 8'd2, 8'd0, 8'd4};

    // Expected outputs after each edge; en=all ones throughout the table.
    // Rising edge: hs rises D+2 edges after pwm is first sampled.
    add(0, 4'b0000, 4'b1111); add(0, 4'b0000, 4'b1111);
    add(1, 4'b0000, 4'b1111); add(1, 4'b0000, 4'b1111);
    add(1, 4'b0010, 4'b0000); add(1, 4'b1010, 4'b0000);
    add(1, 4'b1110, 4'b0000); add(1, 4'b1110, 4'b0000);
    add(1, 4'b1111, 4'b0000); add(1, 4'b1111, 4'b0000);
    // Falling edge: same gaps mirrored.
    add(0, 4'b1111, 4'b0000); add(0, 4'b1111, 4'b0000);
    add(0, 4'b0000, 4'b0010); add(0, 4'b0000, 4'b1010);
    add(0, 4'b0000, 4'b1110); add(0, 4'b0000, 4'b1110);
    add(0, 4'b0000, 4'b1111);
    // Two-cycle pulse: ch0/ch2 never reach HIGH, ch3 (D=1) and ch1 (D=0) do.
    add(1, 4'b0000, 4'b1111); add(1, 4'b0000, 4'b1111);
    add(0, 4'b0010, 4'b0000); add(0, 4'b1010, 4'b0000);
    add(0, 4'b0000, 4'b0111); add(0, 4'b0000, 4'b1111);
    // Back to HIGH, then a one-cycle low glitch rejected in DEAD_F.
    add(1, 4'b0000, 4'b1111); add(1, 4'b0000, 4'b1111);
    add(1, 4'b0010, 4'b0000); add(1, 4'b1010, 4'b0000);
    add(1, 4'b1110, 4'b0000); add(1, 4'b1110, 4'b0000);
    add(1, 4'b1111, 4'b0000);
    add(0, 4'b1111, 4'b0000); add(1, 4'b1111, 4'b0000);
    add(1, 4'b0000, 4'b0010); add(1, 4'b1111, 4'b0000);

    // Reset state
    repeat (2) step();
    chk("reset_hs", 32'(hs), 32'h0);
    chk("reset_ls", 32'(ls), 32'h0);
    chk("reset_fault_sts", 32'(fault_sts), 32'h0);
    rst_n = 1'b1;

    // Table-driven section
    en = 4'hF;
    for (int i = 0; i < tbl.size(); i++) begin
      pwm = {NUM_CH{tbl[i].pwm}};
      step();
      chk($sformatf("tbl%0d_hs", i), 32'(hs), 32'(tbl[i].hs));
      chk($sformatf("tbl%0d_ls", i), 32'(ls), 32'(tbl[i].ls));
      chk($sformatf("tbl%0d_fs", i), 32'(fault_sts), 32'h0);
    end

    // Fault while all channels drive high side
    fault = 1'b1;
    step();
    step();
    chk("fault_pre_hs", 32'(hs), 32'hF);
    chk("fault_pre_sts", 32'(fault_sts), 32'h0);
    step();
    chk("fault_hs", 32'(hs), 32'h0);
    chk("fault_ls", 32'(ls), 32'h0);
    chk("fault_sts", 32'(fault_sts), 32'h1);
    // Clear while fault still present is ignored
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk("clr_ignored_sts", 32'(fault_sts), 32'h1);
    step();
    chk("clr_ignored_sts2", 32'(fault_sts), 32'h1);
    chk("clr_ignored_ls", 32'(ls), 32'h0);
    fault = 1'b0;
    step();
    step();
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk("clr_sts", 32'(fault_sts), 32'h0);
    chk("clr_ls_idle", 32'(ls), 32'h0);
    step();
    chk("clr_ls", 32'(ls), 32'hF);
    chk("clr_hs", 32'(hs), 32'h0);

    // Drop enable in DEAD_R (pwm still high)
    step();
    chk("deadr_hs", 32'(hs), 32'h2);
    chk("deadr_ls", 32'(ls), 32'h0);
    en  = 4'h0;
    pwm = 4'h0;
    step();
    chk("en_off_hs", 32'(hs), 32'h0);
    chk("en_off_ls", 32'(ls), 32'h0);
    step();
    chk("en_off2_ls", 32'(ls), 32'h0);
    en = 4'hF;
    step();
    chk("reen_ls", 32'(ls), 32'hF);
    pwm = 4'hF;
    repeat (3) step();
    chk("reen_gap_hs", 32'(hs), 32'h2);
    chk("reen_gap_ls", 32'(ls), 32'h0);
    repeat (4) step();
    chk("reen_high_hs", 32'(hs), 32'hF);
    chk("reen_high_ls", 32'(ls), 32'h0);

    // Reset mid-gap with the clock stopped
    pwm = 4'h0;
    repeat (3) step();
    chk("gap_ls", 32'(ls), 32'h2);
    clk_run = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_hs", 32'(hs), 32'h0);
    chk("async_rst_ls", 32'(ls), 32'h0);
    chk("async_rst_sts", 32'(fault_sts), 32'h0);
    #10;
    rst_n   = 1'b1;
    clk_run = 1'b1;

    // Random soak: never both sides on
    for (int c = 0; c < 400; c++) begin
      if (c % 20 == 0) begin
        en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        for (int k = 0; k < NUM_CH; k++) dead[k*DT_W +: DT_W] = 8'($urandom_range(0, 5));
      end
      for (int k = 0; k < NUM_CH; k++) if ($urandom_range(0, 7) == 0) pwm[k] = ~pwm[k];
      fault     = ($urandom_range(0, 59) == 0);
      fault_clr = ($urandom_range(0, 9) == 0);
      step();
      chk("overlap", 32'(hs & ls), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
